// File: rtl/cmd_cfg_mc_pkg.sv
// Shared definitions for the command/config decoder: opcodes, response
// codes, FSM state encoding and the AFE gain DAC lookup.
package cmd_cfg_pkg;

  localparam logic [7:0] OP_DUMP_CH  = 8'h01;
  localparam logic [7:0] OP_CFG_GAIN = 8'h02;
  localparam logic [7:0] OP_TRIG_LVL = 8'h03;
  localparam logic [7:0] OP_TRIG_POS = 8'h04;
  localparam logic [7:0] OP_SET_DEC  = 8'h05;
  localparam logic [7:0] OP_TRIG_CFG = 8'h06;
  localparam logic [7:0] OP_TRIG_RD  = 8'h07;
  localparam logic [7:0] OP_EEP_WRT  = 8'h08;
  localparam logic [7:0] OP_EEP_RD   = 8'h09;
  localparam logic [7:0] OP_GAIN_RD  = 8'h0A;

  localparam logic [7:0]  RESP_ACK  = 8'hA5;
  localparam logic [7:0]  RESP_NAK  = 8'hEE;
  localparam logic [7:0]  DAC_CMD   = 8'h13;
  localparam logic [15:0] EEP_DUMMY = 16'hBCBC;

  // Trigger levels outside this window are rejected
  localparam logic [7:0] TRIG_LVL_MIN = 8'd46;
  localparam logic [7:0] TRIG_LVL_MAX = 8'd201;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SPI_WAIT,
    S_EEP_WAIT1,
    S_EEP_WAIT2,
    S_DUMP_WAIT,
    S_RESP_WAIT
  } state_t;

  // DAC code for each 3-bit AFE gain setting
  function automatic logic [7:0] gain_lut(input logic [2:0] g);
    logic [7:0] v;
    case (g)
      3'd0:    v = 8'h02;
      3'd1:    v = 8'h05;
      3'd2:    v = 8'h09;
      3'd3:    v = 8'h14;
      3'd4:    v = 8'h28;
      3'd5:    v = 8'h46;
      3'd6:    v = 8'h6B;
      default: v = 8'hDD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cmd_cfg_mc_if.sv
// UART command/response and SPI bus bundle for cmd_cfg_mc.
//
// Handshake semantics:
//   - cmd is valid whenever cmd_rdy is high; the host holds both until it
//     sees the one-cycle clr_cmd_rdy pulse, then drops cmd_rdy.
//   - send_resp is a one-cycle pulse with resp_data valid in the same cycle
//     and held afterwards; the UART answers later with resp_sent.
//   - wrt_SPI is a one-cycle pulse with SPI_data/ss valid in the same cycle
//     and held; the SPI master answers later with a SPI_done pulse.
// master = the decoder side, slave = the UART/SPI side.
interface cmd_cfg_mc_if #(
  parameter int SS_W = 3
);
  logic [23:0]     cmd;
  logic            cmd_rdy;
  logic            clr_cmd_rdy;
  logic [7:0]      resp_data;
  logic            send_resp;
  logic            resp_sent;
  logic [15:0]     SPI_data;
  logic            wrt_SPI;
  logic [SS_W-1:0] ss;
  logic            SPI_done;
  logic [7:0]      EEP_data;

  modport master (
    input  cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
    output clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
  );

  modport slave (
    output cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
    input  clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
  );
endinterface

// File: rtl/cmd_cfg_mc_spi_tmo_cnt.sv
// Saturating SPI watchdog counter: cleared on each new SPI transaction,
// counts wait cycles and flags when TMO cycles have elapsed.
module spi_tmo_cnt #(
  parameter int TMO = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tmo_o
);
  localparam int W = (TMO < 2) ? 1 : $clog2(TMO + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tmo_o = (cnt_q == W'(TMO));

  // Next count: clear wins, otherwise count up and stop at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (en_i && !tmo_o) cnt_d = cnt_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cmd_cfg_mc.sv
// Scope command/config decoder: latches 24-bit UART commands, holds the
// capture configuration, runs AFE/trigger DAC and EEPROM SPI transfers and
// returns one response byte per command (none for channel dumps).
module cmd_cfg_mc
  import cmd_cfg_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int TRIG_POS_W = 9,
  parameter int SPI_TMO    = 1023,
  parameter int SS_W       = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmd_cfg_mc_if.master          bus,
  input  logic                  set_capture_done,
  input  logic                  dump_done,
  output logic                  dump,
  output logic [1:0]            dump_ch,
  output logic [TRIG_POS_W-1:0] trig_pos,
  output logic [3:0]            decimator,
  output logic [7:0]            trig_cfg,
  output logic [3*NUM_CH-1:0]   afe_gain,
  output state_t                dbg_state
);
  state_t                state_q, state_d;
  logic [23:0]           cmd_q, cmd_d;
  logic [7:0]            trig_cfg_q, trig_cfg_d;
  logic [TRIG_POS_W-1:0] trig_pos_q, trig_pos_d;
  logic [3:0]            dec_q, dec_d;
  logic [3*NUM_CH-1:0]   gain_q, gain_d;
  logic [SS_W-1:0]       ss_q, ss_d;
  logic [1:0]            dump_ch_q, dump_ch_d;
  logic [7:0]            resp_q, resp_d;
  logic [15:0]           spi_q, spi_d;
  logic                  clr_q, clr_d;
  logic                  send_q, send_d;
  logic                  wrt_q, wrt_d;
  logic                  dump_q, dump_d;

  logic       tmo;
  logic       do_resp;
  logic [7:0] resp_val;
  logic [7:0] opcode, b2, b3;
  logic [1:0] ch;
  logic       ch_ok;
  logic       in_wait;

  assign opcode  = cmd_q[23:16];
  assign b2      = cmd_q[15:8];
  assign b3      = cmd_q[7:0];
  assign ch      = b2[1:0];
  assign ch_ok   = (int'(ch) < NUM_CH);
  assign in_wait = (state_q == S_SPI_WAIT) || (state_q == S_EEP_WAIT1) ||
                   (state_q == S_EEP_WAIT2);

  spi_tmo_cnt #(.TMO(SPI_TMO)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (wrt_d),
    .en_i  (in_wait),
    .tmo_o (tmo)
  );

  // Next-state, register updates and pulse generation
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    trig_pos_d = trig_pos_q;
    dec_d      = dec_q;
    gain_d     = gain_q;
    ss_d       = ss_q;
    dump_ch_d  = dump_ch_q;
    resp_d     = resp_q;
    spi_d      = spi_q;
    clr_d      = 1'b0;
    send_d     = 1'b0;
    wrt_d      = 1'b0;
    dump_d     = 1'b0;
    do_resp    = 1'b0;
    resp_val   = RESP_NAK;
    // Capture engine sets the done bit; a DECODE write below overrides it
    trig_cfg_d = set_capture_done ? (trig_cfg_q | 8'h20) : trig_cfg_q;

    case (state_q)
      S_IDLE: begin
        // Skip the cycle where our own clr_cmd_rdy is still in flight so the
        // consumed command is not latched twice
        if (bus.cmd_rdy && !clr_q) begin
          cmd_d   = bus.cmd;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_DUMP_CH: begin
            if (ch_ok) begin
              dump_d    = 1'b1;
              dump_ch_d = ch;
              state_d   = S_DUMP_WAIT;
            end else begin
              do_resp = 1'b1;
            end
          end
          OP_CFG_GAIN: begin
            if (ch_ok) begin
              for (int k = 0; k < NUM_CH; k++)
                if (ch == 2'(k)) gain_d[3*k +: 3] = b2[4:2];
              spi_d   = {DAC_CMD, gain_lut(b2[4:2])};
              ss_d    = SS_W'(ch);
              wrt_d   = 1'b1;
              state_d = S_SPI_WAIT;
            end else begin
              do_resp = 1'b1;
            end
          end
          OP_TRIG_LVL: begin
            if (b3 >= TRIG_LVL_MIN && b3 <= TRIG_LVL_MAX) begin
              spi_d   = {DAC_CMD, b3};
              ss_d    = SS_W'(NUM_CH);
              wrt_d   = 1'b1;
              state_d = S_SPI_WAIT;
            end else begin
              do_resp = 1'b1;
            end
          end
          OP_TRIG_POS: begin
            trig_pos_d = TRIG_POS_W'({b2, b3});
            do_resp    = 1'b1;
            resp_val   = RESP_ACK;
          end
          OP_SET_DEC: begin
            dec_d    = b3[3:0];
            do_resp  = 1'b1;
            resp_val = RESP_ACK;
          end
          OP_TRIG_CFG: begin
            trig_cfg_d = {2'b00, b2[5:0]};
            do_resp    = 1'b1;
            resp_val   = RESP_ACK;
          end
          OP_TRIG_RD: begin
            do_resp  = 1'b1;
            resp_val = trig_cfg_q;
          end
          OP_EEP_WRT: begin
            spi_d   = {2'b01, b2[5:0], b3};
            ss_d    = SS_W'(NUM_CH + 1);
            wrt_d   = 1'b1;
            state_d = S_SPI_WAIT;
          end
          OP_EEP_RD: begin
            spi_d   = {2'b00, b2[5:0], 8'h00};
            ss_d    = SS_W'(NUM_CH + 1);
            wrt_d   = 1'b1;
            state_d = S_EEP_WAIT1;
          end
          OP_GAIN_RD: begin
            do_resp = 1'b1;
            if (ch_ok) begin
              for (int k = 0; k < NUM_CH; k++)
                if (ch == 2'(k)) resp_val = {5'b0, gain_q[3*k +: 3]};
            end
          end
          default: do_resp = 1'b1;
        endcase
      end
      S_SPI_WAIT: begin
        if (bus.SPI_done) begin
          do_resp  = 1'b1;
          resp_val = RESP_ACK;
        end else if (tmo) begin
          do_resp = 1'b1;
        end
      end
      S_EEP_WAIT1: begin
        // Address phase done; clock out a dummy word to read the data byte
        if (bus.SPI_done) begin
          spi_d   = EEP_DUMMY;
          wrt_d   = 1'b1;
          state_d = S_EEP_WAIT2;
        end else if (tmo) begin
          do_resp = 1'b1;
        end
      end
      S_EEP_WAIT2: begin
        if (bus.SPI_done) begin
          do_resp  = 1'b1;
          resp_val = bus.EEP_data;
        end else if (tmo) begin
          do_resp = 1'b1;
        end
      end
      S_DUMP_WAIT: begin
        // The dump engine owns the UART, so no response byte here
        if (dump_done) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RESP_WAIT: begin
        if (bus.resp_sent) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_resp) begin
      resp_d  = resp_val;
      send_d  = 1'b1;
      state_d = S_RESP_WAIT;
    end
  end

  // State, configuration and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      trig_cfg_q <= 8'h20;
      trig_pos_q <= '0;
      dec_q      <= '0;
      gain_q     <= '0;
      ss_q       <= SS_W'(NUM_CH + 1);
      dump_ch_q  <= '0;
      resp_q     <= '0;
      spi_q      <= '0;
      clr_q      <= 1'b0;
      send_q     <= 1'b0;
      wrt_q      <= 1'b0;
      dump_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      trig_cfg_q <= trig_cfg_d;
      trig_pos_q <= trig_pos_d;
      dec_q      <= dec_d;
      gain_q     <= gain_d;
      ss_q       <= ss_d;
      dump_ch_q  <= dump_ch_d;
      resp_q     <= resp_d;
      spi_q      <= spi_d;
      clr_q      <= clr_d;
      send_q     <= send_d;
      wrt_q      <= wrt_d;
      dump_q     <= dump_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_q;
  assign bus.resp_data   = resp_q;
  assign bus.send_resp   = send_q;
  assign bus.SPI_data    = spi_q;
  assign bus.wrt_SPI     = wrt_q;
  assign bus.ss          = ss_q;
  assign dump            = dump_q;
  assign dump_ch         = dump_ch_q;
  assign trig_pos        = trig_pos_q;
  assign decimator       = dec_q;
  assign trig_cfg        = trig_cfg_q;
  assign afe_gain        = gain_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Bench for cmd_cfg_mc: directed commands with hand-computed responses,
// SPI words and dump requests checked by a scoreboard monitor.
module tb_cmd_cfg_mc;
  import cmd_cfg_pkg::*;

  localparam int NUM_CH = 3;
  localparam int TPW    = 9;
  localparam int TMO    = 1023;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (NUM_CH=3) ----------------
  cmd_cfg_mc_if #(.SS_W(3)) bus ();
  logic            set_capture_done, dump_done, dump;
  logic [1:0]      dump_ch;
  logic [TPW-1:0]  trig_pos;
  logic [3:0]      decimator;
  logic [7:0]      trig_cfg;
  logic [3*NUM_CH-1:0] afe_gain;
  state_t          dbg_state;

  cmd_cfg_mc #(.NUM_CH(NUM_CH), .TRIG_POS_W(TPW), .SPI_TMO(TMO), .SS_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .set_capture_done(set_capture_done), .dump_done(dump_done),
    .dump(dump), .dump_ch(dump_ch), .trig_pos(trig_pos),
    .decimator(decimator), .trig_cfg(trig_cfg), .afe_gain(afe_gain),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (NUM_CH=2) ----------------
  cmd_cfg_mc_if #(.SS_W(3)) bus2 ();
  logic       dump2;
  logic [1:0] dump_ch2;
  logic [8:0] trig_pos2;
  logic [3:0] decimator2;
  logic [7:0] trig_cfg2;
  logic [5:0] afe_gain2;
  state_t     dbg_state2;

  cmd_cfg_mc #(.NUM_CH(2), .TRIG_POS_W(9), .SPI_TMO(15), .SS_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .set_capture_done(1'b0), .dump_done(1'b0),
    .dump(dump2), .dump_ch(dump_ch2), .trig_pos(trig_pos2),
    .decimator(decimator2), .trig_cfg(trig_cfg2), .afe_gain(afe_gain2),
    .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int fails     = 0;
  logic [7:0]  exp_resp_q[$];
  logic [18:0] exp_spi_q[$];   // {ss, SPI_data}
  logic [1:0]  exp_dump_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of its expected queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.send_resp) begin
        tests_run++;
        if (exp_resp_q.size() == 0) begin
          fails++;
          $display("FAIL resp: unexpected send_resp data=%h", bus.resp_data);
        end else begin
          logic [7:0] e;
          e = exp_resp_q.pop_front();
          if (bus.resp_data !== e) begin
            fails++;
            $display("FAIL resp: got %h expected %h", bus.resp_data, e);
          end
        end
      end
      if (bus.wrt_SPI) begin
        tests_run++;
        if (exp_spi_q.size() == 0) begin
          fails++;
          $display("FAIL spi: unexpected wrt_SPI ss=%0d data=%h", bus.ss, bus.SPI_data);
        end else begin
          logic [18:0] e;
          e = exp_spi_q.pop_front();
          if ({bus.ss, bus.SPI_data} !== e) begin
            fails++;
            $display("FAIL spi: got ss=%0d data=%h expected ss=%0d data=%h",
                     bus.ss, bus.SPI_data, e[18:16], e[15:0]);
          end
        end
      end
      if (dump) begin
        tests_run++;
        if (exp_dump_q.size() == 0) begin
          fails++;
          $display("FAIL dump: unexpected dump ch=%0d", dump_ch);
        end else begin
          logic [1:0] e;
          e = exp_dump_q.pop_front();
          if (dump_ch !== e) begin
            fails++;
            $display("FAIL dump_ch: got %0d expected %0d", dump_ch, e);
          end
        end
      end
      if (dump2) begin
        tests_run++;
        fails++;
        $display("FAIL dump2: unexpected dump ch=%0d", dump_ch2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Checks the current negedge first, then up to limit more negedges
  task automatic wait_for(input int sel, input int limit, input string nm, output int cyc);
    logic hit;
    cyc = 0;
    forever begin
      case (sel)
        0: hit = bus.wrt_SPI;
        1: hit = bus.send_resp;
        2: hit = bus.clr_cmd_rdy;
        3: hit = dump;
        4: hit = bus2.send_resp;
        default: hit = bus2.clr_cmd_rdy;
      endcase
      if (hit) break;
      if (cyc >= limit) begin
        tests_run++;
        fails++;
        $display("FAIL wait_%s: no event after %0d cycles, required within %0d", nm, cyc, limit);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic issue(input logic [23:0] c);
    @(negedge clk);
    bus.cmd     = c;
    bus.cmd_rdy = 1'b1;
  endtask

  task automatic spi_ack();
    repeat (2) @(negedge clk);
    bus.SPI_done = 1'b1;
    @(negedge clk);
    bus.SPI_done = 1'b0;
  endtask

  task automatic ack_resp();
    int c;
    @(negedge clk);
    bus.resp_sent = 1'b1;
    wait_for(2, 5, "clr", c);
    bus.resp_sent = 1'b0;
    bus.cmd_rdy   = 1'b0;
  endtask

  task automatic finish_resp();
    int c;
    wait_for(1, 20, "send_resp", c);
    ack_resp();
  endtask

  // Command with response only
  task automatic do_resp_cmd(input logic [23:0] c, input logic [7:0] r);
    exp_resp_q.push_back(r);
    issue(c);
    finish_resp();
  endtask

  // Command with one SPI write then ACK
  task automatic do_spi_cmd(input logic [23:0] c, input logic [2:0] s, input logic [15:0] d);
    int cyc;
    exp_spi_q.push_back({s, d});
    exp_resp_q.push_back(RESP_ACK);
    issue(c);
    wait_for(0, 10, "wrt_SPI", cyc);
    spi_ack();
    finish_resp();
  endtask

  // NUM_CH=2 instance: command expected to produce a single response
  task automatic run2(input logic [23:0] c, input logic [7:0] r, input string nm);
    int cyc;
    @(negedge clk);
    bus2.cmd     = c;
    bus2.cmd_rdy = 1'b1;
    wait_for(4, 10, nm, cyc);
    check(nm, {24'h0, bus2.resp_data}, {24'h0, r});
    @(negedge clk);
    bus2.resp_sent = 1'b1;
    wait_for(5, 5, "clr2", cyc);
    bus2.resp_sent = 1'b0;
    bus2.cmd_rdy   = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    bus.cmd = '0; bus.cmd_rdy = 0; bus.resp_sent = 0; bus.SPI_done = 0; bus.EEP_data = 8'h7E;
    bus2.cmd = '0; bus2.cmd_rdy = 0; bus2.resp_sent = 0; bus2.SPI_done = 0; bus2.EEP_data = 8'h00;
    set_capture_done = 0; dump_done = 0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_trig_cfg", {24'h0, trig_cfg}, 32'h20);
    check("rst_trig_pos", {23'h0, trig_pos}, 32'h0);
    check("rst_decimator", {28'h0, decimator}, 32'h0);
    check("rst_afe_gain", {23'h0, afe_gain}, 32'h0);
    check("rst_ss", {29'h0, bus.ss}, 32'd4);
    check("rst_resp_data", {24'h0, bus.resp_data}, 32'h0);
    check("rst_spi_data", {16'h0, bus.SPI_data}, 32'h0);
    check("rst_pulses", {28'h0, bus.send_resp, bus.wrt_SPI, bus.clr_cmd_rdy, dump}, 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Read default trig_cfg
    do_resp_cmd(24'h070000, 8'h20);

    // CFG_GAIN ch1 g=3, with wrt_SPI latency check
    exp_spi_q.push_back({3'd1, 16'h1314});
    exp_resp_q.push_back(RESP_ACK);
    issue(24'h020D00);
    wait_for(0, 10, "wrt_SPI", cyc);
    check("gain_wrt_latency", cyc, 32'd2);
    check("afe_gain_ch1", {23'h0, afe_gain}, 32'h018);
    spi_ack();
    finish_resp();
    do_resp_cmd(24'h0A0100, 8'h03);
    do_resp_cmd(24'h0A0000, 8'h00);
    // Channel 2, gain 7 -> LUT DD
    do_spi_cmd(24'h021E00, 3'd2, 16'h13DD);
    check("afe_gain_ch2", {23'h0, afe_gain}, 32'h1D8);
    do_resp_cmd(24'h0A0200, 8'h07);
    // Out-of-range channel
    do_resp_cmd(24'h0A0300, RESP_NAK);
    do_resp_cmd(24'h020F00, RESP_NAK);
    check("afe_gain_after_bad", {23'h0, afe_gain}, 32'h1D8);

    // Trigger level window
    do_resp_cmd(24'h03002D, RESP_NAK);
    do_resp_cmd(24'h0300CA, RESP_NAK);
    do_spi_cmd(24'h0300C9, 3'd3, 16'h13C9);
    do_spi_cmd(24'h03002E, 3'd3, 16'h132E);

    // Trigger position / decimator
    do_resp_cmd(24'h040123, RESP_ACK);
    check("trig_pos_123", {23'h0, trig_pos}, 32'h123);
    do_resp_cmd(24'h04FFFF, RESP_ACK);
    check("trig_pos_trunc", {23'h0, trig_pos}, 32'h1FF);
    do_resp_cmd(24'h0500AB, RESP_ACK);
    check("decimator", {28'h0, decimator}, 32'hB);

    // trig_cfg write beats a simultaneous set_capture_done
    exp_resp_q.push_back(RESP_ACK);
    issue(24'h06C3C3);
    @(negedge clk);
    set_capture_done = 1'b1;
    @(negedge clk);
    set_capture_done = 1'b0;
    finish_resp();
    check("trig_cfg_prec", {24'h0, trig_cfg}, 32'h03);
    @(negedge clk);
    set_capture_done = 1'b1;
    @(negedge clk);
    set_capture_done = 1'b0;
    check("trig_cfg_capdone", {24'h0, trig_cfg}, 32'h23);
    do_resp_cmd(24'h070000, 8'h23);

    // EEPROM write and read
    do_spi_cmd(24'h08FF5A, 3'd4, 16'h7F5A);
    exp_spi_q.push_back({3'd4, 16'h1500});
    exp_spi_q.push_back({3'd4, 16'hBCBC});
    exp_resp_q.push_back(8'h7E);
    issue(24'h091500);
    wait_for(0, 10, "wrt_SPI", cyc);
    spi_ack();
    wait_for(0, 10, "wrt_SPI_dummy", cyc);
    spi_ack();
    finish_resp();

    // SPI timeout, then a late SPI_done that must be ignored
    exp_spi_q.push_back({3'd4, 16'h4111});
    exp_resp_q.push_back(RESP_NAK);
    issue(24'h080111);
    wait_for(0, 10, "wrt_SPI", cyc);
    wait_for(1, TMO + 50, "tmo_resp", cyc);
    check("tmo_window", (cyc >= TMO - 2 && cyc <= TMO + 4) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    bus.SPI_done = 1'b1;
    @(negedge clk);
    bus.SPI_done = 1'b0;
    repeat (4) @(negedge clk);
    ack_resp();
    repeat (4) @(negedge clk);

    // Unknown opcode
    do_resp_cmd(24'h0B1234, RESP_NAK);

    // Channel dump: no clr_cmd_rdy until dump_done
    exp_dump_q.push_back(2'd2);
    issue(24'h010200);
    wait_for(3, 10, "dump", cyc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_clr_before_done", {31'h0, bus.clr_cmd_rdy}, 32'h0);
    end
    dump_done = 1'b1;
    wait_for(2, 5, "dump_clr", cyc);
    dump_done = 1'b0;
    bus.cmd_rdy = 1'b0;
    do_resp_cmd(24'h010300, RESP_NAK);

    // NUM_CH=2 instance rejects channel 2
    run2(24'h010200, RESP_NAK, "dump_ch2_nch2");
    run2(24'h0A0200, RESP_NAK, "gain_rd_ch2_nch2");
    run2(24'h0A0100, 8'h00, "gain_rd_ch1_nch2");

    // Reset during an SPI wait
    exp_spi_q.push_back({3'd3, 16'h1380});
    issue(24'h030080);
    wait_for(0, 10, "wrt_SPI", cyc);
    @(negedge clk);
    rst_n = 1'b0;
    bus.cmd_rdy = 1'b0;
    @(negedge clk);
    check("midrst_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
    check("midrst_ss", {29'h0, bus.ss}, 32'd4);
    check("midrst_pulses", {28'h0, bus.send_resp, bus.wrt_SPI, bus.clr_cmd_rdy, dump}, 32'h0);
    check("midrst_trig_cfg", {24'h0, trig_cfg}, 32'h20);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_resp_cmd(24'h070000, 8'h20);

    // Nothing left outstanding
    repeat (4) @(negedge clk);
    check("resp_q_empty", exp_resp_q.size(), 32'd0);
    check("spi_q_empty", exp_spi_q.size(), 32'd0);
    check("dump_q_empty", exp_dump_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
